// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame streamer.
// Optional reverse video is enabled by defining OLED_INVERT_EN.
package oled_pkg;

  localparam int INIT_LEN    = 14;
  localparam int FRAME_BYTES = 1024;

  typedef enum logic [2:0] {
    PANEL_RST,
    PANEL_WAIT,
    INIT_LOAD,
    INIT_SHIFT,
    DATA_ADDR,
    DATA_FETCH,
    DATA_SHIFT
  } oled_state_e;

  // Display off, horizontal addressing, charge pump, remap, full window, on.
  localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
    8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8,
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF
  };

endpackage

// File: rtl/oled_frame_streamer_spi_byte_tx.sv
// Mode-0 SPI byte serialiser, MSB first, CLK_DIV clk cycles per half bit.
// Optional reverse video is selected in the parent via OLED_INVERT_EN.
module spi_byte_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       sclk_o,
  output logic       sdin_o,
  output logic       done_o
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic       busy_q;
  logic       sclk_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic       tick;

  assign tick   = busy_q && (div_q == DIV_MAX);
  assign done_o = tick && sclk_q && (bit_q == 3'd0);
  assign sclk_o = sclk_q;
  assign sdin_o = sh_q[7];

  // Data shifts on the falling edge so sdin never moves while sclk is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      div_q  <= 8'd0;
      bit_q  <= 3'd0;
      sh_q   <= 8'd0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      sclk_q <= 1'b0;
      div_q  <= 8'd0;
      bit_q  <= 3'd7;
      sh_q   <= byte_i;
    end else if (busy_q) begin
      if (tick) begin
        div_q <= 8'd0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd0) begin
            busy_q <= 1'b0;
          end else begin
            bit_q <= bit_q - 3'd1;
            sh_q  <= {sh_q[6:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// SSD1306 128x64 streamer: panel reset, init ROM, then endless frame sweep.
// Define OLED_INVERT_EN to XOR every data byte with FF (reverse video).
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int STARTUP_WAIT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       oled_rst_n,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [15:0] WAIT_MAX = 16'(STARTUP_WAIT - 1);
  localparam logic [3:0]  IDX_MAX  = 4'(INIT_LEN - 1);
  localparam logic [9:0]  ADR_MAX  = 10'(FRAME_BYTES - 1);

  oled_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  addr_q, addr_d;
  logic        init_q, init_d;
  logic        fdone_q, fdone_d;
  logic        start;
  logic [7:0]  tx_byte;
  logic [7:0]  data_byte;
  logic        tx_done;

`ifdef OLED_INVERT_EN
  assign data_byte = pixelData ^ 8'hFF;
`else
  assign data_byte = pixelData;
`endif

  spi_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .byte_i (tx_byte),
    .sclk_o (oled_sclk),
    .sdin_o (oled_sdin),
    .done_o (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PANEL_RST;
      cnt_q   <= 16'd0;
      idx_q   <= 4'd0;
      addr_q  <= 10'd0;
      init_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      init_q  <= init_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    init_d     = init_q;
    fdone_d    = 1'b0;
    start      = 1'b0;
    tx_byte    = 8'h00;
    oled_rst_n = 1'b1;
    oled_cs    = 1'b1;
    oled_dc    = 1'b0;
    unique case (state_q)
      PANEL_RST: begin
        oled_rst_n = 1'b0;
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q == WAIT_MAX) begin
          cnt_d   = 16'd0;
          state_d = PANEL_WAIT;
        end
      end
      PANEL_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == WAIT_MAX) begin
          cnt_d   = 16'd0;
          state_d = INIT_LOAD;
        end
      end
      INIT_LOAD: begin
        oled_cs = 1'b0;
        start   = 1'b1;
        tx_byte = INIT_ROM[idx_q];
        state_d = INIT_SHIFT;
      end
      INIT_SHIFT: begin
        oled_cs = 1'b0;
        if (tx_done) begin
          if (idx_q == IDX_MAX) begin
            idx_d   = 4'd0;
            init_d  = 1'b1;
            state_d = DATA_ADDR;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = INIT_LOAD;
          end
        end
      end
      DATA_ADDR: begin
        oled_dc = 1'b1;
        state_d = DATA_FETCH;
      end
      DATA_FETCH: begin
        oled_dc = 1'b1;
        oled_cs = 1'b0;
        start   = 1'b1;
        tx_byte = data_byte;
        state_d = DATA_SHIFT;
      end
      DATA_SHIFT: begin
        oled_dc = 1'b1;
        oled_cs = 1'b0;
        if (tx_done) begin
          addr_d  = addr_q + 10'd1;
          fdone_d = (addr_q == ADR_MAX);
          state_d = DATA_ADDR;
        end
      end
      default: state_d = PANEL_RST;
    endcase
  end

  assign pixelAddress = addr_q;
  assign init_done    = init_q;
  assign frame_done   = fdone_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Scoreboard bench: expected SPI bytes queued up front, monitor decodes the wire.
// Build with OLED_INVERT_EN to expect reverse-video data bytes.
module tb_oled_frame_streamer;

  typedef struct packed {
    logic       dc;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData = 8'h00;
  logic       oled_rst_n;
  logic       oled_cs;
  logic       oled_dc;
  logic       oled_sclk;
  logic       oled_sdin;
  logic       init_done;
  logic       frame_done;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  logic [7:0] rom [0:13] = '{
    8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA1, 8'hC8,
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF
  };

  always #5 clk = ~clk;

  oled_frame_streamer #(
    .CLK_DIV     (2),
    .STARTUP_WAIT(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixelAddress(pixelAddress),
    .pixelData   (pixelData),
    .oled_rst_n  (oled_rst_n),
    .oled_cs     (oled_cs),
    .oled_dc     (oled_dc),
    .oled_sclk   (oled_sclk),
    .oled_sdin   (oled_sdin),
    .init_done   (init_done),
    .frame_done  (frame_done)
  );

  // Renderer model: one registered cycle of latency, data = low address byte.
  always @(posedge clk) pixelData <= pixelAddress[7:0];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dbyte(input int a);
    logic [7:0] v;
    v = 8'(a);
`ifdef OLED_INVERT_EN
    v = v ^ 8'hFF;
`endif
    return v;
  endfunction

  task automatic push_init();
    for (int i = 0; i < 14; i++) q.push_back({1'b0, rom[i]});
  endtask

  task automatic push_data(input int first, input int n);
    for (int i = first; i < first + n; i++) q.push_back({1'b1, dbyte(i)});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(pixelAddress), 32'd0);
    chk({tag, "_rstn"},  32'(oled_rst_n),   32'd0);
    chk({tag, "_cs"},    32'(oled_cs),      32'd1);
    chk({tag, "_dc"},    32'(oled_dc),      32'd0);
    chk({tag, "_sclk"},  32'(oled_sclk),    32'd0);
    chk({tag, "_sdin"},  32'(oled_sdin),    32'd0);
    chk({tag, "_init"},  32'(init_done),    32'd0);
    chk({tag, "_frame"}, 32'(frame_done),   32'd0);
  endtask

  // SPI monitor: decode bytes on sclk rising edges and score them.
  int         nb = 0;
  logic       psclk = 1'b0;
  logic [7:0] sr = 8'h00;
  logic       dcs = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      nb    = 0;
      psclk = 1'b0;
    end else begin
      if (oled_sclk && !psclk) begin
        sr  = {sr[6:0], oled_sdin};
        dcs = oled_dc;
        chk("cs_low_at_rise", 32'(oled_cs), 32'd0);
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (q.size() == 0) begin
            chk("unexpected_byte", 32'({dcs, sr}), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("spi_byte", 32'({dcs, sr}), 32'(e));
          end
        end
      end
      psclk = oled_sclk;
    end
  end

  int         cyc;
  logic [9:0] pa;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    push_init();
    push_data(0, 1024);
    push_data(0, 500);

    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 0)  chk("rstn_c0",  32'(oled_rst_n), 32'd0);
      if (k == 7)  chk("rstn_c7",  32'(oled_rst_n), 32'd0);
      if (k == 8)  chk("rstn_c8",  32'(oled_rst_n), 32'd1);
      if (k == 15) chk("cs_c15",   32'(oled_cs),    32'd1);
      if (k == 16) chk("cs_c16",   32'(oled_cs),    32'd0);
      if (k == 18) chk("sclk_c18", 32'(oled_sclk),  32'd0);
      if (k == 19) chk("sclk_c19", 32'(oled_sclk),  32'd1);
      @(negedge clk);
    end
    cyc = 20;

    while (!init_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_done_cycle", 32'(cyc), 32'd478);
    chk("init_dc_first_data", 32'(oled_dc), 32'd1);

    pa = pixelAddress;
    while (!frame_done && cyc < 40000) begin
      pa = pixelAddress;
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_cycle", 32'(cyc), 32'd35294);
    chk("addr_before_wrap", 32'(pa), 32'd1023);
    chk("addr_after_wrap", 32'(pixelAddress), 32'd0);
    @(negedge clk);
    chk("frame_done_width", 32'(frame_done), 32'd0);
    chk("init_done_held", 32'(init_done), 32'd1);

    cyc = 0;
    while (pixelAddress != 10'd500 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_addr_500", 32'(pixelAddress), 32'd500);
    repeat (12) @(negedge clk);
    chk("mid_byte_sclk_busy", 32'(oled_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    chk("queue_drained_at_abort", 32'(q.size()), 32'd0);

    q.delete();
    push_init();
    push_data(0, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 7)  chk("re_rstn_c7", 32'(oled_rst_n), 32'd0);
      if (k == 8)  chk("re_rstn_c8", 32'(oled_rst_n), 32'd1);
      if (k == 16) chk("re_cs_c16",  32'(oled_cs),    32'd0);
      @(negedge clk);
    end
    cyc = 17;
    while (!init_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("re_init_done_cycle", 32'(cyc), 32'd478);

    cyc = 0;
    while (q.size() != 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
